// File: rtl/shifter_pkg.sv
// Shared constants for the shifter: opcode encodings of S and the default data width.
package shifter_pkg;

    localparam int DATA_LENGTH_DEF = 32;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_ROR = 2'b01;
    localparam logic [1:0] OP_LSR = 2'b10;
    localparam logic [1:0] OP_ASR = 2'b11;

endpackage : shifter_pkg

// File: rtl/shift_right.sv
// Combinational log2(DATA_LENGTH)-stage right barrel shifter with a fill bit.
// Rotate support (wrapped bits per stage) is present only when SHIFTER_ROTATE_EN is defined.
module shift_right #(
    parameter int DATA_LENGTH = 32
) (
    input  logic                           IR,
`ifdef SHIFTER_ROTATE_EN
    input  logic                           rot,
`endif
    input  logic [$clog2(DATA_LENGTH)-1:0] shift,
    input  logic [DATA_LENGTH-1:0]         B,
    output logic [DATA_LENGTH-1:0]         H
);

    localparam int STAGES = $clog2(DATA_LENGTH);

    logic [DATA_LENGTH-1:0] stg [0:STAGES];

    assign stg[0] = B;

    // Stage k moves the word right by 2**k; vacated MSBs take the fill or the wrapped LSBs.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int AMT = 1 << k;
        logic [AMT-1:0] fill;
`ifdef SHIFTER_ROTATE_EN
        assign fill = rot ? stg[k][AMT-1:0] : {AMT{IR}};
`else
        assign fill = {AMT{IR}};
`endif
        assign stg[k+1] = shift[k] ? {fill, stg[k][DATA_LENGTH-1:AMT]} : stg[k];
    end

    assign H = stg[STAGES];

endmodule : shift_right

// File: rtl/shifter.sv
// Registered shifter: LSL/ROR/LSR/ASR built on one right barrel shifter, result one cycle after in_valid.
// SHIFTER_ROTATE_EN enables S=01 rotate right; otherwise S=01 behaves as LSL.
module shifter
    import shifter_pkg::*;
#(
    parameter int DATA_LENGTH = DATA_LENGTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [1:0]                     S,
    input  logic [$clog2(DATA_LENGTH)-1:0] shift,
    input  logic [DATA_LENGTH-1:0]         B,
    output logic [DATA_LENGTH-1:0]         H,
    output logic                           out_valid
);

    // Valid-only handshake: every cycle with in_valid=1 is accepted (no ready, no stall);
    // out_valid pulses for exactly the cycle after, while H holds its value otherwise.

    logic                   is_left;
    logic                   fill;
`ifdef SHIFTER_ROTATE_EN
    logic                   rot;
`endif
    logic [DATA_LENGTH-1:0] core_in;
    logic [DATA_LENGTH-1:0] core_out;
    logic [DATA_LENGTH-1:0] h_next;

    always_comb begin
        is_left = (S == OP_LSL);
`ifdef SHIFTER_ROTATE_EN
        rot     = (S == OP_ROR);
`else
        is_left = is_left | (S == OP_ROR);
`endif
        fill    = (S == OP_ASR) & B[DATA_LENGTH-1];
    end

    // Left shift = reverse, shift right with zero fill, reverse back.
    always_comb begin
        core_in = B;
        for (int i = 0; i < DATA_LENGTH; i++) begin
            core_in[i] = is_left ? B[DATA_LENGTH-1-i] : B[i];
        end
    end

    shift_right #(
        .DATA_LENGTH(DATA_LENGTH)
    ) u_shift_right (
        .IR    (fill),
`ifdef SHIFTER_ROTATE_EN
        .rot   (rot),
`endif
        .shift (shift),
        .B     (core_in),
        .H     (core_out)
    );

    always_comb begin
        h_next = core_out;
        for (int i = 0; i < DATA_LENGTH; i++) begin
            h_next[i] = is_left ? core_out[DATA_LENGTH-1-i] : core_out[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            H         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                H <= h_next;
            end
        end
    end

endmodule : shifter

// File: tb/tb_shifter.sv
// Directed and random checks of the shifter through an expected-result queue.
module tb_shifter;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [1:0]   S;
    logic [4:0]   shift;
    logic [W-1:0] B;
    logic [W-1:0] H;
    logic         out_valid;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_h;
    int           checks;
    int           errors;
    string        tag;

    shifter #(.DATA_LENGTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .S         (S),
        .shift     (shift),
        .B         (B),
        .H         (H),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_op(input logic [1:0] s, input logic [4:0] sh,
                                            input logic [W-1:0] b);
        int amt;
        amt = W - int'(sh);
        case (s)
            2'b00: ref_op = b << sh;
            2'b10: ref_op = b >> sh;
            2'b11: ref_op = $unsigned($signed(b) >>> sh);
`ifdef SHIFTER_ROTATE_EN
            default: ref_op = (b >> sh) | (b << amt);
`else
            default: ref_op = b << sh;
`endif
        endcase
    endfunction

    // One clock: sample outputs 1 time unit after the edge and compare against the queue.
    task automatic cycle();
        logic         exp_v;
        logic [W-1:0] e;
        exp_v = in_valid;
        @(posedge clk);
        #1;
        checks++;
        assert (out_valid === exp_v) else begin
            errors++;
            $error("FAIL %s out_valid observed=%0b expected=%0b", tag, out_valid, exp_v);
        end
        if (exp_v) begin
            e      = exp_q.pop_front();
            last_h = e;
        end
        checks++;
        assert (H === last_h) else begin
            errors++;
            $error("FAIL %s H observed=0x%08h expected=0x%08h", tag, H, last_h);
        end
    endtask

    task automatic drive(input string t, input logic [1:0] s, input logic [4:0] sh,
                         input logic [W-1:0] b, input logic [W-1:0] e);
        tag      = t;
        in_valid = 1'b1;
        S        = s;
        shift    = sh;
        B        = b;
        exp_q.push_back(e);
        cycle();
    endtask

    task automatic idle(input string t);
        tag      = t;
        in_valid = 1'b0;
        S        = 2'($urandom_range(0, 3));
        shift    = 5'($urandom_range(0, 31));
        B        = $urandom;
        cycle();
    endtask

    initial begin
        logic [W-1:0] lsl_exp [0:5];
        logic [W-1:0] lsr_exp [0:5];
        logic [W-1:0] ror_exp;
        logic [1:0]   rs;
        logic [4:0]   rsh;
        logic [W-1:0] rb;

        lsl_exp = '{32'd10, 32'd20, 32'd40, 32'd80, 32'd160, 32'd320};
        lsr_exp = '{32'd10, 32'd5, 32'd2, 32'd1, 32'd0, 32'd0};
`ifdef SHIFTER_ROTATE_EN
        ror_exp = 32'h8000_0002;
`else
        ror_exp = 32'd40;
`endif
        checks   = 0;
        errors   = 0;
        last_h   = '0;
        tag      = "reset";
        rst_n    = 1'b0;
        in_valid = 1'b0;
        S        = 2'b00;
        shift    = '0;
        B        = '0;

        #3;
        checks++;
        assert (H === '0) else begin
            errors++;
            $error("FAIL reset_h observed=0x%08h expected=0x00000000", H);
        end
        checks++;
        assert (out_valid === 1'b0) else begin
            errors++;
            $error("FAIL reset_valid observed=%0b expected=0", out_valid);
        end
        #10;
        rst_n = 1'b1;

        // Back-to-back streams for LSL, LSR, ASR on B=10.
        for (int i = 0; i < 6; i++) drive("lsl10", 2'b00, 5'(i), 32'd10, lsl_exp[i]);
        for (int i = 0; i < 6; i++) drive("lsr10", 2'b10, 5'(i), 32'd10, lsr_exp[i]);
        for (int i = 0; i < 6; i++) drive("asr10", 2'b11, 5'(i), 32'd10, lsr_exp[i]);
        drive("asr_sign", 2'b11, 5'd4, 32'h8000_0000, 32'hF800_0000);
        drive("lsr_sign", 2'b10, 5'd4, 32'h8000_0000, 32'h0800_0000);
        drive("ror10",    2'b01, 5'd2, 32'd10, ror_exp);
        drive("ror_zero", 2'b01, 5'd0, 32'h1234_5678, 32'h1234_5678);
        drive("lsr_max",  2'b10, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001);
        drive("lsl_max",  2'b00, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000);
        drive("asr_max",  2'b11, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);

        // Single pulse: one valid cycle then H held with out_valid low.
        idle("gap");
        drive("pulse", 2'b10, 5'd8, 32'hA5A5_0000, 32'h00A5_A500);
        idle("hold1");
        idle("hold2");
        idle("hold3");

        // Reset in the middle of a stream, between clock edges.
        drive("pre_rst", 2'b00, 5'd1, 32'h0000_0003, 32'h0000_0006);
        in_valid = 1'b1;
        S        = 2'b11;
        shift    = 5'd3;
        B        = 32'hFFFF_0000;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        assert (H === '0) else begin
            errors++;
            $error("FAIL async_rst_h observed=0x%08h expected=0x00000000", H);
        end
        checks++;
        assert (out_valid === 1'b0) else begin
            errors++;
            $error("FAIL async_rst_valid observed=%0b expected=0", out_valid);
        end
        in_valid = 1'b0;
        exp_q.delete();
        last_h = '0;
        #2;
        rst_n = 1'b1;
        idle("post_rst");
        drive("first_after_rst", 2'b10, 5'd1, 32'h0000_0100, 32'h0000_0080);
        idle("post_rst_hold");

        // Random back-to-back traffic with occasional gaps.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle("rand_gap");
            end else begin
                rs  = 2'($urandom_range(0, 3));
                rsh = 5'($urandom_range(0, 31));
                rb  = $urandom;
                drive("rand", rs, rsh, rb, ref_op(rs, rsh, rb));
            end
        end
        idle("drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shifter
